// File: rtl/usb_spi_scheduler.sv
// Two-port round-robin scheduler for MAX3421E register transactions over mode-0 SPI.
// Optional macro USB_SPI_STATUS_EN captures the command-byte MISO bits into status.
module usb_spi_scheduler #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic       clk_clk,
   input  logic       reset_reset,
   input  logic       r0_req,
   input  logic       r0_wr,
   input  logic [4:0] r0_reg,
   input  logic [7:0] r0_wdata,
   output logic [7:0] r0_rdata,
   output logic       r0_done,
   input  logic       r1_req,
   input  logic       r1_wr,
   input  logic [4:0] r1_reg,
   input  logic [7:0] r1_wdata,
   output logic [7:0] r1_rdata,
   output logic       r1_done,
   output logic       spi_sclk,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       spi_cs_n,
   output logic       busy,
   output logic [7:0] status
);

   if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_div_check
      $error("usb_spi_scheduler: CLK_DIV must be in 1..255");
   end

   localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

   typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  bit_q, bit_d;
   logic        sclk_q, sclk_d;
   logic        mosi_q, mosi_d;
   logic        cs_n_q, cs_n_d;
   logic        busy_q, busy_d;
   logic [15:0] shift_q, shift_d;
   logic [7:0]  rx_q, rx_d;
   logic        port_q, port_d;
   logic        last_q, last_d;
   logic        r0_done_q, r0_done_d;
   logic        r1_done_q, r1_done_d;
   logic [7:0]  r0_rdata_q, r0_rdata_d;
   logic [7:0]  r1_rdata_q, r1_rdata_d;
   logic        cnt_end;
   logic        gnt;
   logic [15:0] frame;

   assign cnt_end = (cnt_q == DIV_M1);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;
      busy_d     = busy_q;
      shift_d    = shift_q;
      rx_d       = rx_q;
      port_d     = port_q;
      last_d     = last_q;
      r0_done_d  = 1'b0;
      r1_done_d  = 1'b0;
      r0_rdata_d = r0_rdata_q;
      r1_rdata_d = r1_rdata_q;
      // On a tie the port that did not win last time is granted.
      gnt        = (r0_req && r1_req) ? ~last_q : r1_req;
      frame      = gnt ? {r1_reg, 1'b0, r1_wr, 1'b0, (r1_wr ? r1_wdata : 8'h00)}
                       : {r0_reg, 1'b0, r0_wr, 1'b0, (r0_wr ? r0_wdata : 8'h00)};
      unique case (state_q)
         StIdle: begin
            if (r0_req || r1_req) begin
               port_d  = gnt;
               last_d  = gnt;
               shift_d = frame;
               mosi_d  = frame[15];
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = 8'd0;
               bit_d   = 4'd0;
               rx_d    = 8'h00;
               state_d = StSetup;
            end
         end
         StSetup: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_end) begin
               cnt_d   = 8'd0;
               state_d = StShift;
            end
         end
         StShift: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_end) begin
               cnt_d = 8'd0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[6:0], spi_miso};
               end else begin
                  sclk_d  = 1'b0;
                  shift_d = {shift_q[14:0], 1'b0};
                  mosi_d  = shift_q[14];
                  bit_d   = bit_q + 4'd1;
                  if (bit_q == 4'd15) begin
                     mosi_d  = 1'b0;
                     state_d = StHold;
                  end
               end
            end
         end
         StHold: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_end) begin
               cnt_d   = 8'd0;
               cs_n_d  = 1'b1;
               state_d = StGap;
               if (port_q) begin
                  r1_done_d  = 1'b1;
                  r1_rdata_d = rx_q;
               end else begin
                  r0_done_d  = 1'b1;
                  r0_rdata_d = rx_q;
               end
            end
         end
         StGap: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_end) begin
               cnt_d   = 8'd0;
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q    <= StIdle;
         cnt_q      <= 8'd0;
         bit_q      <= 4'd0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         shift_q    <= 16'h0000;
         rx_q       <= 8'h00;
         port_q     <= 1'b0;
         last_q     <= 1'b1;
         r0_done_q  <= 1'b0;
         r1_done_q  <= 1'b0;
         r0_rdata_q <= 8'h00;
         r1_rdata_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
         busy_q     <= busy_d;
         shift_q    <= shift_d;
         rx_q       <= rx_d;
         port_q     <= port_d;
         last_q     <= last_d;
         r0_done_q  <= r0_done_d;
         r1_done_q  <= r1_done_d;
         r0_rdata_q <= r0_rdata_d;
         r1_rdata_q <= r1_rdata_d;
      end
   end

`ifdef USB_SPI_STATUS_EN
   logic [7:0] cmd_q;
   logic [7:0] status_q;
   logic       cmd_cap;
   logic       done_evt;

   // rx_q holds the full command byte at the 8th falling SCLK edge.
   assign cmd_cap  = (state_q == StShift) && cnt_end && sclk_q && (bit_q == 4'd7);
   assign done_evt = (state_q == StHold) && cnt_end;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         cmd_q    <= 8'h00;
         status_q <= 8'h00;
      end else begin
         if (cmd_cap) cmd_q <= rx_q;
         if (done_evt) status_q <= cmd_q;
      end
   end

   assign status = status_q;
`else
   assign status = 8'h00;
`endif

   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;
   assign spi_cs_n = cs_n_q;
   assign busy     = busy_q;
   assign r0_done  = r0_done_q;
   assign r1_done  = r1_done_q;
   assign r0_rdata = r0_rdata_q;
   assign r1_rdata = r1_rdata_q;

endmodule

// File: tb/tb_usb_spi_scheduler.sv
// Bench for usb_spi_scheduler: CLK_DIV=2 instance (vector table + corner sequences) and a
// CLK_DIV=1 instance for the latch-at-grant check.
module tb_usb_spi_scheduler;

`ifdef USB_SPI_STATUS_EN
   localparam bit STATUS_EN = 1'b1;
`else
   localparam bit STATUS_EN = 1'b0;
`endif

   typedef struct {
      logic        port;
      logic        wr;
      logic [4:0]  rg;
      logic [7:0]  wdata;
      logic [15:0] slave;
      logic [15:0] exp_mosi;
      logic [7:0]  exp_rdata;
      logic [7:0]  exp_status;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance 0, CLK_DIV = 2
   logic       r0_req, r0_wr, r1_req, r1_wr;
   logic [4:0] r0_reg, r1_reg;
   logic [7:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, status0;
   logic       r0_done, r1_done, sclk0, mosi0, miso0, cs_n0, busy0;

   // Instance 1, CLK_DIV = 1
   logic       a_req, a_wr, b_req, b_wr;
   logic [4:0] a_reg, b_reg;
   logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata, status1;
   logic       a_done, b_done, sclk1, mosi1, miso1, cs_n1, busy1;

   usb_spi_scheduler #(.CLK_DIV(2)) dut0 (
      .clk_clk(clk), .reset_reset(rst),
      .r0_req(r0_req), .r0_wr(r0_wr), .r0_reg(r0_reg), .r0_wdata(r0_wdata),
      .r0_rdata(r0_rdata), .r0_done(r0_done),
      .r1_req(r1_req), .r1_wr(r1_wr), .r1_reg(r1_reg), .r1_wdata(r1_wdata),
      .r1_rdata(r1_rdata), .r1_done(r1_done),
      .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_miso(miso0), .spi_cs_n(cs_n0),
      .busy(busy0), .status(status0)
   );

   usb_spi_scheduler #(.CLK_DIV(1)) dut1 (
      .clk_clk(clk), .reset_reset(rst),
      .r0_req(a_req), .r0_wr(a_wr), .r0_reg(a_reg), .r0_wdata(a_wdata),
      .r0_rdata(a_rdata), .r0_done(a_done),
      .r1_req(b_req), .r1_wr(b_wr), .r1_reg(b_reg), .r1_wdata(b_wdata),
      .r1_rdata(b_rdata), .r1_done(b_done),
      .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1), .spi_cs_n(cs_n1),
      .busy(busy1), .status(status1)
   );

   // SPI slave/monitor per instance, sampled on the falling clk edge
   logic        sclk_w [2];
   logic        cs_w   [2];
   logic        mosi_w [2];
   logic        sclk_p [2];
   logic        cs_p   [2];
   logic [15:0] slave_tx [2];
   logic [15:0] mosi_cap [2];
   int          rise_cnt [2];
   int          cs_low [2];
   int          cs_len [2];
   int          hi_run [2];
   int          last_gap [2];
   int          first_rise [2];
   int          last_rise [2];
   int          cyc;

   assign sclk_w[0] = sclk0;
   assign sclk_w[1] = sclk1;
   assign cs_w[0]   = cs_n0;
   assign cs_w[1]   = cs_n1;
   assign mosi_w[0] = mosi0;
   assign mosi_w[1] = mosi1;
   assign miso0 = (rise_cnt[0] < 16) ? slave_tx[0][4'(15 - rise_cnt[0])] : 1'b0;
   assign miso1 = (rise_cnt[1] < 16) ? slave_tx[1][4'(15 - rise_cnt[1])] : 1'b0;

   initial begin
      cyc = 0;
      for (int i = 0; i < 2; i++) begin
         sclk_p[i] = 1'b0; cs_p[i] = 1'b1; slave_tx[i] = 16'h0000; mosi_cap[i] = 16'h0000;
         rise_cnt[i] = 16; cs_low[i] = 0; cs_len[i] = 0; hi_run[i] = 0; last_gap[i] = 0;
         first_rise[i] = 0; last_rise[i] = 0;
      end
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (!cs_w[i]) begin
            if (cs_p[i]) begin
               cs_low[i]   <= 1;
               rise_cnt[i] <= 0;
               mosi_cap[i] <= 16'h0000;
               last_gap[i] <= hi_run[i];
            end else begin
               cs_low[i] <= cs_low[i] + 1;
               if (sclk_w[i] && !sclk_p[i]) begin
                  mosi_cap[i] <= {mosi_cap[i][14:0], mosi_w[i]};
                  if (rise_cnt[i] == 0) first_rise[i] <= cyc;
                  last_rise[i] <= cyc;
                  rise_cnt[i]  <= rise_cnt[i] + 1;
               end
            end
         end else begin
            if (!cs_p[i]) begin
               cs_len[i] <= cs_low[i];
               hi_run[i] <= 1;
            end else begin
               hi_run[i] <= hi_run[i] + 1;
            end
         end
         sclk_p[i] <= sclk_w[i];
         cs_p[i]   <= cs_w[i];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int   n;
      int   b;
      int   extra;
      logic seen;
      slave_tx[0] = v.slave;
      @(negedge clk);
      if (v.port) begin
         r1_wr = v.wr; r1_reg = v.rg; r1_wdata = v.wdata; r1_req = 1'b1;
      end else begin
         r0_wr = v.wr; r0_reg = v.rg; r0_wdata = v.wdata; r0_req = 1'b1;
      end
      seen = 1'b0;
      n = 0;
      while (!seen && n < 400) begin
         @(negedge clk);
         n++;
         seen = v.port ? r1_done : r0_done;
      end
      chk($sformatf("v%0d_done", idx), 32'(seen), 32'd1);
      if (seen) begin
         chk($sformatf("v%0d_rdata", idx), 32'(v.port ? r1_rdata : r0_rdata), 32'(v.exp_rdata));
         chk($sformatf("v%0d_status", idx), 32'(status0), 32'(v.exp_status));
         chk($sformatf("v%0d_cs_at_done", idx), 32'(cs_n0), 32'd1);
      end
      r0_req = 1'b0;
      r1_req = 1'b0;
      b = 0;
      extra = 0;
      while (busy0 && b < 20) begin
         @(negedge clk);
         b++;
         if (r0_done || r1_done) extra++;
      end
      chk($sformatf("v%0d_busy_tail", idx), 32'(b), 32'd2);
      chk($sformatf("v%0d_single_done", idx), 32'(extra), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_mosi", idx), 32'(mosi_cap[0]), 32'(v.exp_mosi));
      chk($sformatf("v%0d_cs_low", idx), 32'(cs_len[0]), 32'd68);
   endtask

   vec_t vecs [5];

   initial begin
      int   n;
      int   k;
      int   cnt;
      int   order [4];
      logic seen;

      vecs[0] = '{1'b0, 1'b1, 5'h11, 8'hA5, 16'h0000, 16'h8AA5, 8'h00, 8'h00};
      vecs[1] = '{1'b1, 1'b0, 5'h19, 8'h55, 16'h3C7E, 16'hC800, 8'h7E,
                  (STATUS_EN ? 8'h3C : 8'h00)};
      vecs[2] = '{1'b0, 1'b0, 5'h1F, 8'hFF, 16'h5AC3, 16'hF800, 8'hC3,
                  (STATUS_EN ? 8'h5A : 8'h00)};
      vecs[3] = '{1'b1, 1'b1, 5'h00, 8'h01, 16'hFF80, 16'h0201, 8'h80,
                  (STATUS_EN ? 8'hFF : 8'h00)};
      vecs[4] = '{1'b0, 1'b1, 5'h0A, 8'h3C, 16'h8118, 16'h523C, 8'h18,
                  (STATUS_EN ? 8'h81 : 8'h00)};

      {r0_req, r0_wr, r1_req, r1_wr} = 4'b0;
      {r0_reg, r1_reg} = 10'h0;
      {r0_wdata, r1_wdata} = 16'h0;
      {a_req, a_wr, b_req, b_wr} = 4'b0;
      {a_reg, b_reg} = 10'h0;
      {a_wdata, b_wdata} = 16'h0;
      rst = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst_cs_n", 32'(cs_n0), 32'd1);
      chk("rst_sclk_mosi", 32'({sclk0, mosi0}), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'({r0_done, r1_done}), 32'd0);
      chk("rst_rdata", 32'({r0_rdata, r1_rdata}), 32'd0);
      chk("rst_status", 32'(status0), 32'd0);
      chk("rst_cs_n_div1", 32'(cs_n1), 32'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // Both ports request together after reset and keep requesting: 0,1,0,1
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      slave_tx[0] = 16'h0000;
      r0_wr = 1'b1; r0_reg = 5'h01; r0_wdata = 8'h11;
      r1_wr = 1'b1; r1_reg = 5'h02; r1_wdata = 8'h22;
      @(negedge clk);
      r0_req = 1'b1;
      r1_req = 1'b1;
      k = 0;
      n = 0;
      while (k < 4 && n < 2000) begin
         @(negedge clk);
         n++;
         if (r0_done) begin order[k] = 0; k++; end
         else if (r1_done) begin order[k] = 1; k++; end
         if (k == 4) begin r0_req = 1'b0; r1_req = 1'b0; end
      end
      r0_req = 1'b0;
      r1_req = 1'b0;
      chk("arb_count", 32'(k), 32'd4);
      for (int i = 0; i < k; i++) chk($sformatf("arb_order%0d", i), 32'(order[i]), 32'(i % 2));
      // CS_N high for the GAP state plus the IDLE arbitration cycle
      chk("arb_gap", 32'(last_gap[0]), 32'd3);
      n = 0;
      while (busy0 && n < 20) begin @(negedge clk); n++; end
      chk("arb_idle", 32'(busy0), 32'd0);

      // One-cycle r1 pulse during port 0 SHIFT is never served
      slave_tx[0] = 16'h0000;
      cnt = 0;
      r0_wr = 1'b0; r0_reg = 5'h04; r0_req = 1'b1;
      n = 0;
      while (rise_cnt[0] != 3 && n < 200) begin @(negedge clk); n++; end
      chk("pulse_reached_shift", 32'(rise_cnt[0]), 32'd3);
      r1_req = 1'b1;
      @(negedge clk);
      r1_req = 1'b0;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 400) begin
         @(negedge clk);
         n++;
         seen = r0_done;
         if (r1_done) cnt++;
      end
      chk("pulse_r0_done", 32'(seen), 32'd1);
      r0_req = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (r1_done || busy0) cnt++;
      end
      chk("pulse_no_r1", 32'(cnt), 32'd0);

      // Asynchronous reset mid-SHIFT, then a pending r1 request restarts cleanly
      slave_tx[0] = 16'h3C7E;
      r1_wr = 1'b0; r1_reg = 5'h19; r1_wdata = 8'h00; r1_req = 1'b1;
      n = 0;
      while (rise_cnt[0] != 7 && n < 200) begin @(negedge clk); n++; end
      chk("rst_mid_reached", 32'(rise_cnt[0]), 32'd7);
      chk("rst_mid_busy_before", 32'(busy0), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_cs_n", 32'(cs_n0), 32'd1);
      chk("rst_mid_sclk", 32'(sclk0), 32'd0);
      chk("rst_mid_busy", 32'(busy0), 32'd0);
      chk("rst_mid_no_done", 32'(r1_done), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 400) begin @(negedge clk); n++; seen = r1_done; end
      chk("rst_mid_fresh_done", 32'(seen), 32'd1);
      chk("rst_mid_rdata", 32'(r1_rdata), 32'h7E);
      r1_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mid_mosi", 32'(mosi_cap[0]), 32'hC800);
      chk("rst_mid_cs_low", 32'(cs_len[0]), 32'd68);
      n = 0;
      while (busy0 && n < 20) begin @(negedge clk); n++; end

      // CLK_DIV=1: write data latched at grant, later input change ignored
      slave_tx[1] = 16'hA55A;
      cnt = 0;
      a_wr = 1'b1; a_reg = 5'h03; a_wdata = 8'h5C; a_req = 1'b1;
      n = 0;
      while (cs_n1 && n < 50) begin @(negedge clk); n++; end
      chk("div1_granted", 32'(cs_n1), 32'd0);
      repeat (3) @(negedge clk);
      a_wdata = 8'hFF;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         seen = a_done;
         if (b_done) cnt++;
      end
      chk("div1_done", 32'(seen), 32'd1);
      chk("div1_rdata", 32'(a_rdata), 32'h5A);
      chk("div1_status", 32'(status1), 32'(STATUS_EN ? 8'hA5 : 8'h00));
      a_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("div1_mosi", 32'(mosi_cap[1]), 32'h1A5C);
      chk("div1_cs_low", 32'(cs_len[1]), 32'd34);
      chk("div1_rises", 32'(rise_cnt[1]), 32'd16);
      chk("div1_sclk_period", 32'(last_rise[1] - first_rise[1]), 32'd30);
      chk("div1_no_port1", 32'(cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
